// File: rtl/tenthirty_pkg.sv
// Shared definitions for the Ten-and-a-Half round controller:
// state encoding, result one-hot codes, default thresholds and card weighting.
package tenthirty_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_P_DRAW  = 3'd1,
        ST_P_WAIT  = 3'd2,
        ST_D_DRAW  = 3'd3,
        ST_D_CHECK = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // One-hot {win, draw, lose}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_WIN  = 3'b100;
    localparam logic [2:0] RES_DRAW = 3'b010;
    localparam logic [2:0] RES_LOSE = 3'b001;

    localparam int unsigned DEF_MAX_CARDS         = 5;
    localparam int unsigned DEF_LIMIT_HALF        = 21;
    localparam int unsigned DEF_DEALER_STAND_HALF = 14;

    // Ranks 1-10 count face value (2*val half-points); everything else is half a point.
    function automatic logic [5:0] card_weight(input logic [3:0] rank);
        logic [5:0] w;
        if (rank >= 4'd1 && rank <= 4'd10) begin
            w = {1'b0, rank, 1'b0};
        end else begin
            w = 6'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tenthirty_hand_acc.sv
// One hand of cards: running total in half-points, card count and bust flag.
module tenthirty_hand_acc
    import tenthirty_pkg::*;
#(
    parameter int unsigned LIMIT_HALF = DEF_LIMIT_HALF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add,
    input  logic [3:0] card_val,
    output logic [5:0] total,
    output logic [2:0] count,
    output logic       bust
);

    localparam logic [5:0] LIMIT = 6'(LIMIT_HALF);

    logic [5:0] total_q, total_d;
    logic [2:0] count_q, count_d;

    // Next total/count: clear wins over add
    always_comb begin
        total_d = total_q;
        count_d = count_q;
        if (clear) begin
            total_d = '0;
            count_d = '0;
        end else if (add) begin
            total_d = total_q + card_weight(card_val);
            count_d = count_q + 3'd1;
        end
    end

    // Hand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
            count_q <= '0;
        end else begin
            total_q <= total_d;
            count_q <= count_d;
        end
    end

    assign total = total_q;
    assign count = count_q;
    assign bust  = (total_q > LIMIT);

endmodule

// File: rtl/tenthirty_round_ctrl.sv
// Ten-and-a-Half round sequencer: button edges, card req/ack handshake,
// player/dealer hands, dealer draw policy and registered round result.
// Optional macro TENTHIRTY_FIVE_CARD_EN enables the five-card win rule.
module tenthirty_round_ctrl
    import tenthirty_pkg::*;
#(
    parameter int unsigned MAX_CARDS         = DEF_MAX_CARDS,
    parameter int unsigned DEALER_STAND_HALF = DEF_DEALER_STAND_HALF,
    parameter int unsigned LIMIT_HALF        = DEF_LIMIT_HALF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_hit,
    input  logic       btn_stand,
    output logic       card_req,
    input  logic       card_ack,
    input  logic [3:0] card_val,
    output logic [5:0] player_half,
    output logic [5:0] dealer_half,
    output logic [2:0] player_cnt,
    output logic [2:0] dealer_cnt,
    output logic [2:0] state_o,
    output logic [2:0] result,
    output logic       round_done
);

    localparam logic [2:0] MAXC  = 3'(MAX_CARDS);
    localparam logic [5:0] LIMIT = 6'(LIMIT_HALF);
    localparam logic [5:0] STAND = 6'(DEALER_STAND_HALF);

    state_t     state_q, state_d;
    logic       card_req_q, card_req_d;
    logic [2:0] result_q, result_d;
    logic       round_done_q, round_done_d;
    logic       hit_prev_q, stand_prev_q;

    logic       hit_edge, stand_edge, ack_fire;
    logic       round_clear, p_add, d_add;
    logic       go_done;
    logic [2:0] res_sel;
    logic [5:0] p_total_next;
    logic [2:0] p_cnt_next;

    logic [5:0] p_total, d_total;
    logic [2:0] p_cnt, d_cnt;
    logic       p_bust, d_bust;

    assign hit_edge     = btn_hit & ~hit_prev_q;
    assign stand_edge   = btn_stand & ~stand_prev_q;
    assign ack_fire     = card_req_q & card_ack;
    assign p_total_next = p_total + card_weight(card_val);
    assign p_cnt_next   = p_cnt + 3'd1;

    tenthirty_hand_acc #(.LIMIT_HALF(LIMIT_HALF)) u_player (
        .clk      (clk),
        .rst      (rst),
        .clear    (round_clear),
        .add      (p_add),
        .card_val (card_val),
        .total    (p_total),
        .count    (p_cnt),
        .bust     (p_bust)
    );

    tenthirty_hand_acc #(.LIMIT_HALF(LIMIT_HALF)) u_dealer (
        .clk      (clk),
        .rst      (rst),
        .clear    (round_clear),
        .add      (d_add),
        .card_val (card_val),
        .total    (d_total),
        .count    (d_cnt),
        .bust     (d_bust)
    );

    // Round sequencing: next state, handshake request and result selection
    always_comb begin
        state_d      = state_q;
        card_req_d   = 1'b0;
        result_d     = result_q;
        round_done_d = round_done_q;
        round_clear  = 1'b0;
        p_add        = 1'b0;
        d_add        = 1'b0;
        go_done      = 1'b0;
        res_sel      = RES_NONE;

        case (state_q)
            ST_IDLE: begin
                if (hit_edge) begin
                    round_clear = 1'b1;
                    state_d     = ST_P_DRAW;
                end
            end

            ST_P_DRAW: begin
                card_req_d = ~ack_fire;
                if (ack_fire) begin
                    p_add = 1'b1;
                    // Decide on the total this card produces, not the stale one
                    if (p_total_next > LIMIT) begin
                        go_done = 1'b1;
                        res_sel = RES_LOSE;
                    end else if (p_cnt_next == MAXC) begin
`ifdef TENTHIRTY_FIVE_CARD_EN
                        go_done = 1'b1;
                        res_sel = RES_WIN;
`else
                        state_d = ST_D_DRAW;
`endif
                    end else begin
                        state_d = ST_P_WAIT;
                    end
                end
            end

            ST_P_WAIT: begin
                if (stand_edge) begin
                    state_d = ST_D_DRAW;
                end else if (hit_edge) begin
                    state_d = ST_P_DRAW;
                end
            end

            ST_D_DRAW: begin
                card_req_d = ~ack_fire;
                if (ack_fire) begin
                    d_add   = 1'b1;
                    state_d = ST_D_CHECK;
                end
            end

            ST_D_CHECK: begin
                if (d_bust) begin
                    go_done = 1'b1;
                    res_sel = RES_WIN;
                end else if (d_total < STAND && d_cnt < MAXC) begin
                    state_d = ST_D_DRAW;
`ifdef TENTHIRTY_FIVE_CARD_EN
                end else if (d_cnt == MAXC) begin
                    go_done = 1'b1;
                    res_sel = (p_cnt == MAXC) ? RES_DRAW : RES_LOSE;
`endif
                end else begin
                    go_done = 1'b1;
                    if (p_bust) begin
                        res_sel = RES_LOSE;
                    end else if (p_total > d_total) begin
                        res_sel = RES_WIN;
                    end else if (p_total == d_total) begin
                        res_sel = RES_DRAW;
                    end else begin
                        res_sel = RES_LOSE;
                    end
                end
            end

            ST_DONE: begin
                // Stand takes priority on coincident edges, as in P_WAIT
                if (stand_edge) begin
                    state_d      = ST_IDLE;
                    result_d     = RES_NONE;
                    round_done_d = 1'b0;
                end else if (hit_edge) begin
                    round_clear  = 1'b1;
                    state_d      = ST_P_DRAW;
                    result_d     = RES_NONE;
                    round_done_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_done) begin
            state_d      = ST_DONE;
            result_d     = res_sel;
            round_done_d = 1'b1;
        end
    end

    // Control registers: state, handshake, result and button history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            card_req_q   <= 1'b0;
            result_q     <= RES_NONE;
            round_done_q <= 1'b0;
            hit_prev_q   <= 1'b0;
            stand_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            card_req_q   <= card_req_d;
            result_q     <= result_d;
            round_done_q <= round_done_d;
            hit_prev_q   <= btn_hit;
            stand_prev_q <= btn_stand;
        end
    end

    assign card_req    = card_req_q;
    assign player_half = p_total;
    assign dealer_half = d_total;
    assign player_cnt  = p_cnt;
    assign dealer_cnt  = d_cnt;
    assign state_o     = state_q;
    assign result      = result_q;
    assign round_done  = round_done_q;

endmodule

// File: tb/tb_tenthirty_round_ctrl.sv
// Self-checking bench for tenthirty_round_ctrl: a round-level model tracks
// totals, counts and outcome; a negedge process compares every cycle.
module tb_tenthirty_round_ctrl;

    localparam int S_IDLE = 0, S_P_DRAW = 1, S_P_WAIT = 2, S_D_DRAW = 3, S_DONE = 5;
    localparam int R_WIN = 4, R_DRAW = 2, R_LOSE = 1;
    localparam int PH_IDLE = 0, PH_PDRAW = 1, PH_PWAIT = 2, PH_DEAL = 3, PH_DONE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_hit = 1'b0;
    logic       btn_stand = 1'b0;
    logic       card_ack = 1'b0;
    logic [3:0] card_val = 4'd0;
    logic       card_req;
    logic [5:0] player_half, dealer_half;
    logic [2:0] player_cnt, dealer_cnt, state_o, result;
    logic       round_done;

    tenthirty_round_ctrl #(
        .MAX_CARDS         (5),
        .DEALER_STAND_HALF (14),
        .LIMIT_HALF        (21)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_hit     (btn_hit),
        .btn_stand   (btn_stand),
        .card_req    (card_req),
        .card_ack    (card_ack),
        .card_val    (card_val),
        .player_half (player_half),
        .dealer_half (dealer_half),
        .player_cnt  (player_cnt),
        .dealer_cnt  (dealer_cnt),
        .state_o     (state_o),
        .result      (result),
        .round_done  (round_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Round model
    int m_ph = 0, m_dh = 0, m_pc = 0, m_dc = 0, m_res = 0, m_done = 0;
    int m_phase = PH_IDLE;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int weight(input int v);
        return (v >= 1 && v <= 10) ? 2 * v : 1;
    endfunction

    function automatic void model_zero();
        m_ph = 0; m_dh = 0; m_pc = 0; m_dc = 0;
    endfunction

    function automatic void finish_round(input int r);
        m_res = r; m_done = 1; m_phase = PH_DONE;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("player_half", int'(player_half), m_ph);
            check("dealer_half", int'(dealer_half), m_dh);
            check("player_cnt",  int'(player_cnt),  m_pc);
            check("dealer_cnt",  int'(dealer_cnt),  m_dc);
            check("result",      int'(result),      m_res);
            check("round_done",  int'(round_done),  m_done);
        end
    end

    // One-cycle button press; model applies the edge as the controller should
    task automatic press(input bit h, input bit s);
        @(negedge clk);
        btn_hit = h; btn_stand = s;
        @(posedge clk); #1;
        case (m_phase)
            PH_IDLE:  if (h) begin model_zero(); m_phase = PH_PDRAW; end
            PH_PWAIT: begin
                if (s) m_phase = PH_DEAL;
                else if (h) m_phase = PH_PDRAW;
            end
            PH_DONE: begin
                if (s) begin m_res = 0; m_done = 0; m_phase = PH_IDLE; end
                else if (h) begin model_zero(); m_res = 0; m_done = 0; m_phase = PH_PDRAW; end
            end
            default: ;
        endcase
        @(negedge clk);
        btn_hit = 1'b0; btn_stand = 1'b0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (card_req) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL card_req_timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    function automatic int compare_totals();
        if (m_ph > m_dh) return R_WIN;
        if (m_ph == m_dh) return R_DRAW;
        return R_LOSE;
    endfunction

    // Serve one card when requested and update the model's hand and outcome
    task automatic give(input int v);
        bit got;
        wait_req(got);
        if (got) begin
            card_ack = 1'b1; card_val = 4'(v);
            @(posedge clk); #1;
            card_ack = 1'b0;
            if (m_phase == PH_PDRAW) begin
                m_ph += weight(v); m_pc++;
                if (m_ph > 21) finish_round(R_LOSE);
                else if (m_pc == 5) begin
`ifdef TENTHIRTY_FIVE_CARD_EN
                    finish_round(R_WIN);
`else
                    m_phase = PH_DEAL;
`endif
                end else m_phase = PH_PWAIT;
            end else if (m_phase == PH_DEAL) begin
                m_dh += weight(v); m_dc++;
                @(posedge clk); #1;
                if (m_dh > 21) finish_round(R_WIN);
                else if (m_dh < 14 && m_dc < 5) ;
`ifdef TENTHIRTY_FIVE_CARD_EN
                else if (m_dc == 5) finish_round((m_pc == 5) ? R_DRAW : R_LOSE);
`endif
                else finish_round(compare_totals());
            end
        end
    endtask

    initial begin
        bit got;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_state", int'(state_o), S_IDLE);
        check("rst_card_req", int'(card_req), 0);
        check("rst_result", int'(result), 0);

        // Stand in IDLE is ignored; hit starts a round, request 2 cycles later
        press(0, 1);
        check("idle_stand_ignored", int'(state_o), S_IDLE);
        press(1, 0);
        check("hit_to_pdraw", int'(state_o), S_P_DRAW);
        check("req_not_yet", int'(card_req), 0);
        @(posedge clk); #1;
        check("req_latency", int'(card_req), 1);
        give(10);
        check("p1_half", int'(player_half), 20);
        check("p1_cnt", int'(player_cnt), 1);
        check("p1_state", int'(state_o), S_P_WAIT);
        check("p1_req_low", int'(card_req), 0);

        // Player busts at 24
        press(1, 0);
        give(2);
        check("bust_half", int'(player_half), 24);
        check("bust_state", int'(state_o), S_DONE);
        check("bust_result", int'(result), 3'b001);
        check("bust_dealer_cnt", int'(dealer_cnt), 0);

        // Player 21, dealer 6,3 -> 18, win
        press(1, 0);
        check("newround_half", int'(player_half), 0);
        give(10); press(1, 0); give(12);
        check("p21", int'(player_half), 21);
        press(0, 1);
        check("stand_to_ddraw", int'(state_o), S_D_DRAW);
        give(6);
        check("dealer_redraw", int'(state_o), S_D_DRAW);
        check("dealer_12", int'(dealer_half), 12);
        give(3);
        check("dealer_18", int'(dealer_half), 18);
        check("win_result", int'(result), 3'b100);
        check("win_dcnt", int'(dealer_cnt), 2);

        // Stand from DONE to IDLE holds totals; then 5 vs dealer 13,11,5,2 = 16 -> lose
        press(0, 1);
        check("done_to_idle", int'(state_o), S_IDLE);
        check("idle_hold_total", int'(player_half), 21);
        press(1, 0);
        give(5); press(0, 1);
        give(13); give(11); give(5);
        check("dealer_12_draws", int'(state_o), S_D_DRAW);
        give(2);
        check("dealer_16", int'(dealer_half), 16);
        check("dealer4_cnt", int'(dealer_cnt), 4);
        check("lose16", int'(result), 3'b001);

        // Hit and stand together in P_WAIT: stand wins
        press(1, 0);
        give(4);
        press(1, 1);
        check("both_to_ddraw", int'(state_o), S_D_DRAW);
        give(10);
        check("both_pcnt", int'(player_cnt), 1);
        check("both_result", int'(result), 3'b001);

        // Five player cards of rank 12
        press(1, 0);
        give(12);
        for (int i = 0; i < 4; i++) begin
            press(1, 0);
            give(12);
        end
        check("five_half", int'(player_half), 5);
        check("five_cnt", int'(player_cnt), 5);
`ifdef TENTHIRTY_FIVE_CARD_EN
        check("five_win", int'(result), 3'b100);
        check("five_dcnt", int'(dealer_cnt), 0);
`else
        check("five_to_dealer", int'(state_o), S_D_DRAW);
        give(10);
        check("five_lose", int'(result), 3'b001);
        check("five_dcnt", int'(dealer_cnt), 1);
`endif

        // Dealer stops at five cards of rank 11 (total 5)
        press(1, 0);
        give(10); press(0, 1);
        for (int i = 0; i < 5; i++) give(11);
        check("d5_half", int'(dealer_half), 5);
        check("d5_state", int'(state_o), S_DONE);
`ifdef TENTHIRTY_FIVE_CARD_EN
        check("d5_result", int'(result), 3'b001);
`else
        check("d5_result", int'(result), 3'b100);
`endif

        // Dropped edge in P_DRAW, then reset mid dealer handshake
        press(1, 0);
        press(0, 1);
        check("stand_dropped", int'(state_o), S_P_DRAW);
        give(10);
        press(0, 1);
        wait_req(got);
        #1 rst = 1'b1;
        model_zero(); m_res = 0; m_done = 0; m_phase = PH_IDLE;
        #1;
        check("rst_req_drop", int'(card_req), 0);
        check("rst_phalf", int'(player_half), 0);
        check("rst_state_async", int'(state_o), S_IDLE);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        card_ack = 1'b1; card_val = 4'd10;
        @(posedge clk); #1;
        card_ack = 1'b0;
        check("late_ack_half", int'(player_half), 0);
        check("late_ack_state", int'(state_o), S_IDLE);

        // Recovers after reset
        press(1, 0);
        give(1);
        check("post_rst_half", int'(player_half), 2);
        @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
